// File: rtl/sched_pkg.sv
// Shared types for the scheduler queue-head arbiter.
package sched_pkg;

  typedef enum logic {
    SEL_FIXED = 1'b0,
    SEL_RR    = 1'b1
  } sel_mode_e;

  typedef enum logic {
    ARB_IDLE,
    ARB_OFFER
  } arb_state_e;

endpackage

// File: rtl/sched_head_arbiter_prio_enc.sv
// prio_enc_from: find-first-set in req, searching upward from start and
// wrapping from N-1 back to 0.
//   req   : request vector
//   start : first index examined (must be < N)
//   found : any bit of req set
//   idx   : index of the first set bit at or after start (wrapped)
module prio_enc_from #(
  parameter int unsigned N     = 16,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    logic [IDX_W:0] pos;
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      // Explicit wrap so N need not be a power of two.
      pos = {1'b0, start} + (IDX_W+1)'(i);
      if (pos >= (IDX_W+1)'(N)) begin
        pos = pos - (IDX_W+1)'(N);
      end
      if (!found && req[pos[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/sched_head_arbiter.sv
// Registered queue-head selector: picks one eligible TID slot (fixed
// priority or round-robin) and offers it on a valid/ready handshake.
//   clk, rst_n       : clock, synchronous active-low reset
//   in_tid           : TID per slot
//   schden_flag_sel  : per-slot eligible flag
//   sel_mode         : 0 fixed priority, 1 round-robin
//   qhead_ready      : dispatch accepts the offered head
//   qhead_valid/tid/idx : offered head
//   grant_onehot     : one-hot of qhead_idx in the accept cycle
module sched_head_arbiter
  import sched_pkg::*;
#(
  parameter int unsigned       N_ENTRIES   = 16,
  parameter int unsigned       TID_W       = 4,
  parameter logic [TID_W-1:0]  DEFAULT_TID = 4'hF,
  localparam int unsigned      IDX_W       = $clog2(N_ENTRIES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [TID_W-1:0]     in_tid [N_ENTRIES-1:0],
  input  logic [N_ENTRIES-1:0] schden_flag_sel,
  input  logic                 sel_mode,
  input  logic                 qhead_ready,
  output logic                 qhead_valid,
  output logic [TID_W-1:0]     qhead_tid,
  output logic [IDX_W-1:0]     qhead_idx,
  output logic [N_ENTRIES-1:0] grant_onehot
);

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     next_ptr;
  logic [IDX_W-1:0]     enc_start;
  logic [N_ENTRIES-1:0] cand;
  logic                 accept;
  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic                 valid_d;
  logic [TID_W-1:0]     tid_d;
  logic [IDX_W-1:0]     idx_d;

  // Reset drops an in-flight offer without a grant pulse.
  assign accept = qhead_valid & qhead_ready & rst_n;

  always_comb begin
    grant_onehot = '0;
    if (accept) begin
      grant_onehot[qhead_idx] = 1'b1;
    end
  end

  // The grant doubles as the suppression mask for a stale flag.
  assign cand     = schden_flag_sel & ~grant_onehot;
  assign next_ptr = (qhead_idx == IDX_W'(N_ENTRIES - 1)) ? '0 : qhead_idx + IDX_W'(1);

  always_comb begin
    enc_start = '0;
    if (sel_mode_e'(sel_mode) == SEL_RR) begin
      enc_start = accept ? next_ptr : rr_ptr;
    end
  end

  prio_enc_from #(
    .N     (N_ENTRIES),
    .IDX_W (IDX_W)
  ) u_enc (
    .req   (cand),
    .start (enc_start),
    .found (win_found),
    .idx   (win_idx)
  );

  always_comb begin
    state_d = state_q;
    valid_d = qhead_valid;
    tid_d   = qhead_tid;
    idx_d   = qhead_idx;
    unique case (state_q)
      ARB_IDLE: begin
        if (win_found) begin
          valid_d = 1'b1;
          tid_d   = in_tid[win_idx];
          idx_d   = win_idx;
          state_d = ARB_OFFER;
        end else begin
          valid_d = 1'b0;
          tid_d   = DEFAULT_TID;
        end
      end
      ARB_OFFER: begin
        if (accept) begin
          if (win_found) begin
            valid_d = 1'b1;
            tid_d   = in_tid[win_idx];
            idx_d   = win_idx;
          end else begin
            valid_d = 1'b0;
            tid_d   = DEFAULT_TID;
            state_d = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      qhead_valid <= 1'b0;
      qhead_tid   <= DEFAULT_TID;
      qhead_idx   <= '0;
      rr_ptr      <= '0;
    end else begin
      state_q     <= state_d;
      qhead_valid <= valid_d;
      qhead_tid   <= tid_d;
      qhead_idx   <= idx_d;
      if (accept) begin
        rr_ptr <= next_ptr;
      end
    end
  end

endmodule

// File: tb/tb_sched_head_arbiter.sv
module tb_sched_head_arbiter;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   in_tid [15:0];
  logic [15:0]  flags;
  logic         sel_mode;
  logic         ready;
  logic         qhead_valid;
  logic [3:0]   qhead_tid;
  logic [3:0]   qhead_idx;
  logic [15:0]  grant_onehot;

  int errors = 0;
  int checks = 0;

  // Reference model of the offered head.
  bit       m_valid;
  bit [3:0] m_tid;
  int       m_idx;
  int       m_ptr;

  always #5 clk = ~clk;

  sched_head_arbiter #(
    .N_ENTRIES   (16),
    .TID_W       (4),
    .DEFAULT_TID (4'hF)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_tid          (in_tid),
    .schden_flag_sel (flags),
    .sel_mode        (sel_mode),
    .qhead_ready     (ready),
    .qhead_valid     (qhead_valid),
    .qhead_tid       (qhead_tid),
    .qhead_idx       (qhead_idx),
    .grant_onehot    (grant_onehot)
  );

  function automatic int find_from(input logic [15:0] c, input int s);
    for (int k = 0; k < N; k++) begin
      if (c[(s + k) % N]) return (s + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [15:0] exp_grant();
    logic [15:0] g;
    g = '0;
    if (m_valid && ready && rst_n) g[m_idx] = 1'b1;
    return g;
  endfunction

  // Advance the model across one rising edge using the current inputs.
  task automatic model_step();
    bit          acc;
    logic [15:0] c;
    int          s, w;
    acc = m_valid && ready;
    if (!rst_n) begin
      m_valid = 0; m_tid = 4'hF; m_idx = 0; m_ptr = 0;
    end else if (!(m_valid && !ready)) begin
      c = flags;
      if (acc) c[m_idx] = 1'b0;
      s = sel_mode ? (acc ? (m_idx + 1) % N : m_ptr) : 0;
      w = find_from(c, s);
      if (acc) m_ptr = (m_idx + 1) % N;
      if (w >= 0) begin
        m_valid = 1; m_tid = in_tid[w]; m_idx = w;
      end else begin
        m_valid = 0; m_tid = 4'hF;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_tids();
    for (int i = 0; i < N; i++) in_tid[i] = 4'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ready = 1'b0; flags = '0; sel_mode = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    randomize_tids();
    do_reset();
    checks++;
    if (qhead_valid !== 1'b0 || qhead_tid !== 4'hF || qhead_idx !== 4'd0) begin
      errors++;
      $display("FAIL reset: valid=%b tid=%h idx=%0d, want 0 F 0", qhead_valid, qhead_tid, qhead_idx);
    end
    checks++;
    if (grant_onehot !== 16'h0) begin
      errors++;
      $display("FAIL reset_grant: got %h want 0000", grant_onehot);
    end
  endtask

  task automatic test_fixed();
    do_reset();
    sel_mode = 1'b0; flags = 16'h0A00;
    cycle();
    checks++;
    if (qhead_valid !== 1'b1 || qhead_idx !== 4'd9 || qhead_tid !== in_tid[9]) begin
      errors++;
      $display("FAIL fixed_head: valid=%b idx=%0d tid=%h, want 1 9 %h", qhead_valid, qhead_idx, qhead_tid, in_tid[9]);
    end
    ready = 1'b1; flags = 16'h0;
    #1;
    checks++;
    if (grant_onehot !== 16'h0200) begin
      errors++;
      $display("FAIL fixed_grant: got %h want 0200", grant_onehot);
    end
    cycle();
    checks++;
    if (qhead_valid !== 1'b0 || qhead_tid !== 4'hF) begin
      errors++;
      $display("FAIL empty: valid=%b tid=%h, want 0 F", qhead_valid, qhead_tid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    sel_mode = 1'b1; flags = 16'hFFFF; ready = 1'b1;
    cycle();
    for (int k = 0; k < 18; k++) begin
      checks++;
      if (qhead_valid !== 1'b1 || qhead_idx !== 4'(k % N) || qhead_tid !== in_tid[k % N]) begin
        errors++;
        $display("FAIL rr_seq[%0d]: valid=%b idx=%0d tid=%h, want 1 %0d %h",
                 k, qhead_valid, qhead_idx, qhead_tid, k % N, in_tid[k % N]);
      end
      checks++;
      if (grant_onehot !== (16'h1 << (k % N))) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got %h want %h", k, grant_onehot, 16'h1 << (k % N));
      end
      cycle();
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] tid3;
    do_reset();
    sel_mode = 1'b0; flags = 16'h0008;
    cycle();
    tid3 = in_tid[3];
    for (int k = 0; k < 5; k++) begin
      flags = '0; sel_mode = ~sel_mode;
      cycle();
      checks++;
      if (qhead_valid !== 1'b1 || qhead_idx !== 4'd3 || qhead_tid !== tid3 || grant_onehot !== 16'h0) begin
        errors++;
        $display("FAIL hold[%0d]: valid=%b idx=%0d tid=%h grant=%h, want 1 3 %h 0000",
                 k, qhead_valid, qhead_idx, qhead_tid, grant_onehot, tid3);
      end
    end
    ready = 1'b1;
    #1;
    checks++;
    if (grant_onehot !== 16'h0008) begin
      errors++;
      $display("FAIL hold_release_grant: got %h want 0008", grant_onehot);
    end
    cycle();
    checks++;
    if (qhead_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_drain: valid=%b want 0", qhead_valid);
    end
  endtask

  task automatic test_rr_wrap();
    int exp_idx [2] = '{0, 14};
    do_reset();
    sel_mode = 1'b1; flags = 16'h4000;
    cycle();
    checks++;
    if (qhead_idx !== 4'd14 || qhead_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_setup: valid=%b idx=%0d, want 1 14", qhead_valid, qhead_idx);
    end
    ready = 1'b1; flags = 16'h4001;
    for (int k = 0; k < 2; k++) begin
      cycle();
      checks++;
      if (qhead_valid !== 1'b1 || qhead_idx !== 4'(exp_idx[k])) begin
        errors++;
        $display("FAIL wrap[%0d]: valid=%b idx=%0d, want 1 %0d", k, qhead_valid, qhead_idx, exp_idx[k]);
      end
    end
    ready = 1'b0;
  endtask

  task automatic test_stale_flag();
    do_reset();
    sel_mode = 1'b0; flags = 16'h0003;
    cycle();
    ready = 1'b1;
    cycle();
    checks++;
    if (qhead_valid !== 1'b1 || qhead_idx !== 4'd1) begin
      errors++;
      $display("FAIL stale: valid=%b idx=%0d, want 1 1", qhead_valid, qhead_idx);
    end
    ready = 1'b0;
  endtask

  task automatic test_reset_in_offer();
    do_reset();
    sel_mode = 1'b1; flags = 16'h0020;
    cycle();
    ready = 1'b1; flags = 16'h0040;
    cycle();
    checks++;
    if (qhead_valid !== 1'b1 || qhead_idx !== 4'd6) begin
      errors++;
      $display("FAIL rst_setup: valid=%b idx=%0d, want 1 6", qhead_valid, qhead_idx);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (grant_onehot !== 16'h0) begin
      errors++;
      $display("FAIL rst_no_grant: got %h want 0000", grant_onehot);
    end
    cycle();
    checks++;
    if (qhead_valid !== 1'b0 || qhead_tid !== 4'hF || qhead_idx !== 4'd0) begin
      errors++;
      $display("FAIL rst_offer: valid=%b tid=%h idx=%0d, want 0 F 0", qhead_valid, qhead_tid, qhead_idx);
    end
    rst_n = 1'b1; ready = 1'b0; flags = 16'hFFFF;
    cycle();
    checks++;
    if (qhead_idx !== 4'd0 || qhead_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_ptr: valid=%b idx=%0d, want 1 0", qhead_valid, qhead_idx);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      flags    = 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 7) == 0) flags = '0;
      sel_mode = 1'($urandom);
      ready    = ($urandom_range(0, 3) != 0);
      rst_n    = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 9) == 0) randomize_tids();
      #1;
      checks++;
      if (grant_onehot !== exp_grant()) begin
        errors++;
        $display("FAIL rand_grant[%0d]: got %h want %h", k, grant_onehot, exp_grant());
      end
      cycle();
      checks++;
      if (qhead_valid !== m_valid || qhead_tid !== m_tid || qhead_idx !== 4'(m_idx)) begin
        errors++;
        $display("FAIL rand_head[%0d]: valid=%b tid=%h idx=%0d, want %b %h %0d",
                 k, qhead_valid, qhead_tid, qhead_idx, m_valid, m_tid, m_idx);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; ready = 1'b0; flags = '0; sel_mode = 1'b0;
    for (int i = 0; i < N; i++) in_tid[i] = '0;
    m_valid = 0; m_tid = 4'hF; m_idx = 0; m_ptr = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_fixed();
    test_back_to_back();
    test_backpressure();
    test_rr_wrap();
    test_stale_flag();
    test_reset_in_offer();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
